// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback result buffer.
// The bypass path in alu_wb_stage is enabled by defining ALU_WB_BYPASS_EN.
package alu_wb_pkg;

    localparam int DEF_DEPTH  = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_X0     = 0;

    // One buffered result at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic                  cmp;
    } alu_wb_entry_t;

    // Occupancy classification of the result queue.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // Map an occupancy count onto its occupancy state.
    function automatic occ_state_t occ_of(input int cnt, input int depth);
        if (cnt == 0) begin
            return OCC_EMPTY;
        end else if (cnt >= depth) begin
            return OCC_FULL;
        end else begin
            return OCC_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Result queue for alu_wb_stage: per-entry storage with valid bits,
// wrap-around pointers and an occupancy count. Full/empty come from the
// count, never from pointer equality. Flush wins over push and pop.
module alu_wb_fifo
    import alu_wb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             flush,
    input  logic [ADDR_W-1:0]                push_addr,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             push_cmp,
    output logic                             head_valid,
    output logic [ADDR_W-1:0]                head_addr,
    output logic [DATA_W-1:0]                head_data,
    output logic                             head_cmp,
    output logic [DEPTH-1:0]                 ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]     ent_data,
    output logic [$clog2(DEPTH)-1:0]         rd_ptr,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]             valid_reg;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_reg;
    logic [DEPTH-1:0][DATA_W-1:0] data_reg;
    logic [DEPTH-1:0]             cmp_reg;
    logic [PW-1:0]                wr_ptr_reg;
    logic [PW-1:0]                rd_ptr_reg;
    logic [CW-1:0]                count_reg;
    logic [CW-1:0]                count_next;
    occ_state_t                   occ_reg;
    occ_state_t                   occ_next;
    logic                         push_ok;
    logic                         pop_ok;

    // Guard against pushing into a full queue or popping an empty one.
    assign push_ok = push & (occ_reg != OCC_FULL);
    assign pop_ok  = pop  & (occ_reg != OCC_EMPTY);

    // Next occupancy count and its classification.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count_reg + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - CW'(1);
        end
        occ_next = occ_of(int'(count_next), DEPTH);
    end

    // Count, occupancy state and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            occ_reg    <= OCC_EMPTY;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            occ_reg   <= occ_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Per-entry storage: written at the write pointer, retired at the read pointer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    addr_reg[gi]  <= '0;
                    data_reg[gi]  <= '0;
                    cmp_reg[gi]   <= 1'b0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                    addr_reg[gi]  <= push_addr;
                    data_reg[gi]  <= push_data;
                    cmp_reg[gi]   <= push_cmp;
                end else if (pop_ok && (rd_ptr_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign head_valid = valid_reg[rd_ptr_reg];
    assign head_addr  = addr_reg[rd_ptr_reg];
    assign head_data  = data_reg[rd_ptr_reg];
    assign head_cmp   = cmp_reg[rd_ptr_reg];
    assign ent_valid  = valid_reg;
    assign ent_addr   = addr_reg;
    assign ent_data   = data_reg;
    assign rd_ptr     = rd_ptr_reg;
    assign count      = count_reg;
    assign full       = (occ_reg == OCC_FULL);

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage after the ALU: filters results that do not write a
// register, queues the rest, drains them to the register file through a
// valid/ready handshake and offers a forwarding lookup over queued results.
// Define ALU_WB_BYPASS_EN to let a result reach wb_* in the same cycle
// when the queue is empty.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid_i,
    input  logic [DATA_W-1:0]        alu_result_i,
    input  logic                     alu_cmp_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic                     rd_we_i,
    input  logic                     flush_i,
    output logic                     ex_ready_o,
    output logic                     wb_valid_o,
    output logic [ADDR_W-1:0]        wb_addr_o,
    output logic [DATA_W-1:0]        wb_data_o,
    output logic                     wb_cmp_o,
    input  logic                     wb_ready_i,
    input  logic [ADDR_W-1:0]        fwd_addr_i,
    output logic                     fwd_hit_o,
    output logic [DATA_W-1:0]        fwd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic                         head_valid;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic                         head_cmp;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [PW-1:0]                rd_ptr;
    logic                         fifo_full;
    logic                         store_req;
    logic                         bypass;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fwd_nonzero;
    logic [DEPTH-1:0]             fwd_match;

    // Ready depends only on registered occupancy, never on wb_ready_i.
    assign ex_ready_o = ~fifo_full;

    // Results targeting x0 or not writing rd complete the handshake but are dropped.
    assign store_req = alu_valid_i & ex_ready_o & rd_we_i
                     & (rd_addr_i != ADDR_W'(REG_X0));

`ifdef ALU_WB_BYPASS_EN
    assign bypass    = store_req & (count_o == '0) & ~flush_i & ~rst;
    assign fifo_push = store_req & ~(bypass & wb_ready_i);
`else
    assign bypass    = 1'b0;
    assign fifo_push = store_req;
`endif

    assign fifo_pop = head_valid & wb_ready_i;

    alu_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (flush_i),
        .push_addr  (rd_addr_i),
        .push_data  (alu_result_i),
        .push_cmp   (alu_cmp_i),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .head_cmp   (head_cmp),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr),
        .ent_data   (ent_data),
        .rd_ptr     (rd_ptr),
        .count      (count_o),
        .full       (fifo_full)
    );

    // Present the queue head, or the bypassed result when nothing is queued.
    always_comb begin
        wb_valid_o = head_valid | bypass;
        wb_addr_o  = '0;
        wb_data_o  = '0;
        wb_cmp_o   = 1'b0;
        if (head_valid) begin
            wb_addr_o = head_addr;
            wb_data_o = head_data;
            wb_cmp_o  = head_cmp;
        end else if (bypass) begin
            wb_addr_o = rd_addr_i;
            wb_data_o = alu_result_i;
            wb_cmp_o  = alu_cmp_i;
        end
    end

    assign fwd_nonzero = (fwd_addr_i != ADDR_W'(REG_X0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd_match
            assign fwd_match[gi] = ent_valid[gi] & fwd_nonzero
                                 & (ent_addr[gi] == fwd_addr_i);
        end
    endgenerate

    // Walk entries oldest to youngest from the read pointer; the last match wins.
    always_comb begin
        fwd_hit_o  = |fwd_match;
        fwd_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (fwd_match[rd_ptr + PW'(k)]) begin
                fwd_data_o = ent_data[rd_ptr + PW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage at DEPTH=2, DATA_W=32, ADDR_W=5.
// Also builds with ALU_WB_BYPASS_EN defined; the first push then completes
// through the bypass path instead of the queue.
module tb_alu_wb_stage;

`ifdef ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid_i;
    logic [31:0] alu_result_i;
    logic        alu_cmp_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        flush_i;
    logic        ex_ready_o;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_cmp_o;
    logic        wb_ready_i;
    logic [4:0]  fwd_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;

    alu_wb_stage #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid_i  (alu_valid_i),
        .alu_result_i (alu_result_i),
        .alu_cmp_i    (alu_cmp_i),
        .rd_addr_i    (rd_addr_i),
        .rd_we_i      (rd_we_i),
        .flush_i      (flush_i),
        .ex_ready_o   (ex_ready_o),
        .wb_valid_o   (wb_valid_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .wb_cmp_o     (wb_cmp_o),
        .wb_ready_i   (wb_ready_i),
        .fwd_addr_i   (fwd_addr_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic we, input logic c);
        alu_valid_i  = v;
        rd_addr_i    = rd;
        alu_result_i = d;
        rd_we_i      = we;
        alu_cmp_i    = c;
    endtask

    initial begin
        rst = 1'b1;
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        fwd_addr_i = 5'd0;
        tick();
        tick();

        // Reset state
        chk("rst_ex_ready", ex_ready_o, 1);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_data",  wb_data_o, 0);
        chk("rst_count",    count_o, 0);
        chk("rst_fwd_hit",  fwd_hit_o, 0);
        $display("step reset released");
        rst = 1'b0;
        tick();

        // Single result, register file ready
        wb_ready_i = 1'b1;
        alu(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        chk("t1_ex_ready", ex_ready_o, 1);
        chk("t1_wb_valid_same", wb_valid_o, BYP);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t1_count", count_o, BYP ? 0 : 1);
        chk("t1_wb_valid", wb_valid_o, !BYP);
        chk("t1_wb_addr", wb_addr_o, BYP ? 0 : 5);
        chk("t1_wb_data", wb_data_o, BYP ? 32'h0 : 32'hDEAD_BEEF);
        chk("t1_wb_cmp", wb_cmp_o, !BYP);
        tick();
        chk("t1_count_drained", count_o, 0);
        chk("t1_wb_valid_drained", wb_valid_o, 0);
        $display("step single push rd=5 done");

        // Backpressure with three back-to-back results
        wb_ready_i = 1'b0;
        alu(1'b1, 5'd1, 32'h101, 1'b1, 1'b0);
        tick();
        chk("t2_count1", count_o, 1);
        chk("t2_ready1", ex_ready_o, 1);
        alu(1'b1, 5'd2, 32'h102, 1'b1, 1'b0);
        tick();
        chk("t2_count2", count_o, 2);
        chk("t2_ready_full", ex_ready_o, 0);
        alu(1'b1, 5'd3, 32'h103, 1'b1, 1'b0);
        tick();
        chk("t2_count_held", count_o, 2);
        chk("t2_ready_held", ex_ready_o, 0);
        chk("t2_head1", wb_addr_o, 1);
        chk("t2_data1", wb_data_o, 32'h101);
        wb_ready_i = 1'b1;
        tick();
        chk("t2_count_pop", count_o, 1);
        chk("t2_head2", wb_addr_o, 2);
        chk("t2_ready_again", ex_ready_o, 1);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t2_count_pushpop", count_o, 1);
        chk("t2_head3", wb_addr_o, 3);
        chk("t2_data3", wb_data_o, 32'h103);
        tick();
        chk("t2_count_empty", count_o, 0);
        chk("t2_wb_valid_empty", wb_valid_o, 0);
        $display("step backpressure rd=1,2,3 done");

        // Filtered results: rd=0 and rd_we=0
        alu(1'b1, 5'd0, 32'h1234, 1'b1, 1'b0);
        #1;
        chk("t3_ready_x0", ex_ready_o, 1);
        chk("t3_wb_valid_x0", wb_valid_o, 0);
        tick();
        chk("t3_count_x0", count_o, 0);
        alu(1'b1, 5'd7, 32'h5678, 1'b0, 1'b0);
        #1;
        chk("t3_wb_valid_nowe", wb_valid_o, 0);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t3_count_nowe", count_o, 0);
        chk("t3_wb_valid_after", wb_valid_o, 0);
        $display("step filtered pushes done");

        // Forwarding: youngest match wins, x0 never hits
        wb_ready_i = 1'b0;
        alu(1'b1, 5'd4, 32'h11, 1'b1, 1'b0);
        tick();
        alu(1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        fwd_addr_i = 5'd4;
        #1;
        chk("t4_fwd_hit", fwd_hit_o, 1);
        chk("t4_fwd_data", fwd_data_o, 32'h22);
        chk("t4_head_data", wb_data_o, 32'h11);
        fwd_addr_i = 5'd0;
        #1;
        chk("t4_fwd_hit_x0", fwd_hit_o, 0);
        chk("t4_fwd_data_x0", fwd_data_o, 0);
        fwd_addr_i = 5'd9;
        #1;
        chk("t4_fwd_hit_miss", fwd_hit_o, 0);
        // Pop the oldest, then enqueue a younger rd=4 into the wrapped slot
        wb_ready_i = 1'b1;
        fwd_addr_i = 5'd4;
        #1;
        chk("t4_fwd_head_popping", fwd_hit_o, 1);
        tick();
        wb_ready_i = 1'b0;
        alu(1'b1, 5'd4, 32'h33, 1'b1, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t4_count_wrap", count_o, 2);
        chk("t4_fwd_data_wrap", fwd_data_o, 32'h33);
        chk("t4_head_wrap", wb_data_o, 32'h22);
        $display("step forwarding rd=4 done");

        // Flush while full, with a push attempted in the same cycle
        flush_i = 1'b1;
        alu(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        #1;
        chk("t5_ready_flush_cycle", ex_ready_o, 0);
        tick();
        flush_i = 1'b0;
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        fwd_addr_i = 5'd9;
        #1;
        chk("t5_count", count_o, 0);
        chk("t5_wb_valid", wb_valid_o, 0);
        chk("t5_fwd_dropped", fwd_hit_o, 0);
        chk("t5_ready", ex_ready_o, 1);
        // Flush a partial queue together with an accepted push
        alu(1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
        tick();
        chk("t5_count_partial", count_o, 1);
        alu(1'b1, 5'd6, 32'h67, 1'b1, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        fwd_addr_i = 5'd6;
        #1;
        chk("t5_count_partial_flush", count_o, 0);
        chk("t5_fwd_partial_flush", fwd_hit_o, 0);
        $display("step flush done");

        // Asynchronous reset with two entries queued
        alu(1'b1, 5'd10, 32'hA, 1'b1, 1'b0);
        tick();
        alu(1'b1, 5'd11, 32'hB, 1'b1, 1'b0);
        tick();
        alu(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        fwd_addr_i = 5'd10;
        #1;
        chk("t6_count_before", count_o, 2);
        chk("t6_fwd_before", fwd_hit_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_count", count_o, 0);
        chk("t6_wb_valid", wb_valid_o, 0);
        chk("t6_wb_addr", wb_addr_o, 0);
        chk("t6_wb_data", wb_data_o, 0);
        chk("t6_ex_ready", ex_ready_o, 1);
        chk("t6_fwd_hit", fwd_hit_o, 0);
        chk("t6_fwd_data", fwd_data_o, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_count_after", count_o, 0);
        $display("step async reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
